// File: rtl/kernel_sched_pkg.sv
// -----------------------------------------------------------------------------
// kernel_sched_pkg
// Shared definitions for the 3x3 window-fetch coprocessor:
//   - PIX_W     : width of one RGB444 pixel (12 bits)
//   - WIN_TAPS  : number of pixels in a 3x3 window
//   - COORD_W   : width of the row/column coordinate outputs
//   - sched_state_e : scheduler FSM states (IDLE/FETCH/HOLD/DONE)
//   - tapRowSel/tapColSel : map a tap index 0..8 onto its row/column offset
//     selector, where 0 means -1, 1 means 0 and 2 means +1.
// No ports (package).
// -----------------------------------------------------------------------------
package kernel_sched_pkg;

  localparam int PIX_W    = 12;
  localparam int WIN_TAPS = 9;
  localparam int COORD_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // Taps are numbered row-major: 0..2 are the row above, 3..5 the centre row,
  // 6..8 the row below.
  function automatic logic [1:0] tapRowSel(input logic [3:0] tap);
    logic [1:0] sel;
    case (tap)
      4'd0, 4'd1, 4'd2: sel = 2'd0;
      4'd3, 4'd4, 4'd5: sel = 2'd1;
      default:          sel = 2'd2;
    endcase
    return sel;
  endfunction

  // Within each row the taps go left, centre, right.
  function automatic logic [1:0] tapColSel(input logic [3:0] tap);
    logic [1:0] sel;
    case (tap)
      4'd0, 4'd3, 4'd6: sel = 2'd0;
      4'd1, 4'd4, 4'd7: sel = 2'd1;
      default:          sel = 2'd2;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/kernel_sched_if.sv
// -----------------------------------------------------------------------------
// kernel_sched_if
// Bundles the control, pixel-memory and window-output signals of kernel_sched.
//   start      : begin a full-image pass
//   busy/done  : pass in progress / one-cycle completion pulse
//   rd_en/rd_addr/rd_data : pixel-memory read port (data one cycle after rd_en)
//   win_valid/win_ready   : window handshake towards the gray converter
//   rgb_out0/1/2          : window rows r-1/r/r+1, each {col c-1, c, c+1}
//   cur_row/cur_col       : centre coordinate of the presented window
// Modport slave is the scheduler side, modport master the environment side.
// -----------------------------------------------------------------------------
interface kernel_sched_if #(
  parameter int ADDR_W = 19
);
  import kernel_sched_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [PIX_W-1:0]     rd_data;
  logic                 win_valid;
  logic                 win_ready;
  logic [3*PIX_W-1:0]   rgb_out0;
  logic [3*PIX_W-1:0]   rgb_out1;
  logic [3*PIX_W-1:0]   rgb_out2;
  logic [COORD_W-1:0]   cur_row;
  logic [COORD_W-1:0]   cur_col;

  modport slave (
    input  start, rd_data, win_ready,
    output busy, done, rd_en, rd_addr, win_valid,
           rgb_out0, rgb_out1, rgb_out2, cur_row, cur_col
  );

  modport master (
    output start, rd_data, win_ready,
    input  busy, done, rd_en, rd_addr, win_valid,
           rgb_out0, rgb_out1, rgb_out2, cur_row, cur_col
  );

endinterface

// File: rtl/kernel_addr_gen.sv
// -----------------------------------------------------------------------------
// kernel_addr_gen
// Turns a window centre plus a tap index into a pixel-memory address. The tap's
// neighbour coordinate is clamped to the image so edge pixels are replicated.
//   row_i, col_i : window centre coordinate
//   tap_i        : tap index 0..8 (row-major within the 3x3 window)
//   addr_o       : clampedRow*IMG_W + clampedCol, computed at ADDR_W width
// -----------------------------------------------------------------------------
module kernel_addr_gen
  import kernel_sched_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic [COORD_W-1:0] row_i,
  input  logic [COORD_W-1:0] col_i,
  input  logic [3:0]         tap_i,
  output logic [ADDR_W-1:0]  addr_o
);

  localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);

  logic [1:0]         rowSel;
  logic [1:0]         colSel;
  logic [COORD_W-1:0] effRow;
  logic [COORD_W-1:0] effCol;

  // Pick the neighbour row/column for this tap, holding it at the image border
  // instead of stepping outside, then form the linear address. Every term is
  // widened to ADDR_W before the multiply so the product cannot wrap early.
  always_comb begin
    rowSel = tapRowSel(tap_i);
    colSel = tapColSel(tap_i);

    case (rowSel)
      2'd0:    effRow = (row_i == '0) ? '0 : row_i - ONE;
      2'd2:    effRow = (row_i >= LAST_ROW) ? LAST_ROW : row_i + ONE;
      default: effRow = row_i;
    endcase

    case (colSel)
      2'd0:    effCol = (col_i == '0) ? '0 : col_i - ONE;
      2'd2:    effCol = (col_i >= LAST_COL) ? LAST_COL : col_i + ONE;
      default: effCol = col_i;
    endcase

    addr_o = ADDR_W'(effRow) * ADDR_W'(IMG_W) + ADDR_W'(effCol);
  end

endmodule

// File: rtl/kernel_sched.sv
// -----------------------------------------------------------------------------
// kernel_sched
// Walks every pixel of an IMG_W x IMG_H image in raster order. For each centre
// pixel it reads the 3x3 neighbourhood (edge-replicated) from pixel memory and
// presents it as a window until the downstream path accepts it.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : kernel_sched_if.slave (start/busy/done, memory read port, window
//          handshake, window rows and centre coordinate)
// Per window: 9 read cycles, 1 cycle for the last read data, then HOLD, so a
// window is offered every 11 cycles when win_ready stays high.
// -----------------------------------------------------------------------------
module kernel_sched
  import kernel_sched_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic           clk,
  input  logic           rst,
  kernel_sched_if.slave  bus
);

  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);

  sched_state_e       state_q;
  logic [3:0]         fetchCnt_q;
  logic [COORD_W-1:0] row_q;
  logic [COORD_W-1:0] col_q;
  logic               rdEn_q;
  logic [ADDR_W-1:0]  rdAddr_q;
  logic [PIX_W-1:0]   pix_q [WIN_TAPS];

  logic [COORD_W-1:0] row_d;
  logic [COORD_W-1:0] col_d;
  logic [3:0]         tap_d;
  logic               issueRd;
  logic               lastWin;
  logic [ADDR_W-1:0]  genAddr;

  // Decide which read (if any) goes out on the next cycle and for which centre.
  // rd_en/rd_addr are registered, so the tap for the next cycle is prepared
  // here: tap 0 of a new centre when a pass starts or a window is accepted,
  // otherwise the tap after the one currently being read. fetchCnt_q counts
  // FETCH cycles 0..9; reads happen on counts 0..8.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    tap_d   = 4'd0;
    issueRd = 1'b0;
    lastWin = (row_q == LAST_ROW) && (col_q == LAST_COL);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          row_d   = '0;
          col_d   = '0;
          issueRd = 1'b1;
        end
      end
      FETCH: begin
        if (fetchCnt_q < 4'd8) begin
          tap_d   = fetchCnt_q + 4'd1;
          issueRd = 1'b1;
        end
      end
      HOLD: begin
        if (bus.win_ready && !lastWin) begin
          if (col_q < LAST_COL) begin
            col_d = col_q + ONE;
          end else begin
            col_d = '0;
            row_d = row_q + ONE;
          end
          issueRd = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  kernel_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .row_i  (row_d),
    .col_i  (col_d),
    .tap_i  (tap_d),
    .addr_o (genAddr)
  );

  // Scheduler FSM. Reset wins over everything else. In FETCH, read data
  // arrives one cycle after its strobe, so the slot written on count n is
  // tap n-1; count 9 stores the last tap and moves to HOLD. The window
  // registers are only written in FETCH, which keeps them steady through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetchCnt_q <= 4'd0;
      row_q      <= '0;
      col_q      <= '0;
      rdEn_q     <= 1'b0;
      rdAddr_q   <= '0;
      for (int i = 0; i < WIN_TAPS; i++) begin
        pix_q[i] <= '0;
      end
    end else begin
      rdEn_q   <= issueRd;
      rdAddr_q <= issueRd ? genAddr : '0;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= FETCH;
            fetchCnt_q <= 4'd0;
            row_q      <= row_d;
            col_q      <= col_d;
          end
        end
        FETCH: begin
          if (fetchCnt_q != 4'd0) begin
            pix_q[fetchCnt_q - 4'd1] <= bus.rd_data;
          end
          if (fetchCnt_q == 4'd9) begin
            state_q <= HOLD;
          end else begin
            fetchCnt_q <= fetchCnt_q + 4'd1;
          end
        end
        HOLD: begin
          if (bus.win_ready) begin
            if (lastWin) begin
              state_q <= DONE;
            end else begin
              state_q    <= FETCH;
              fetchCnt_q <= 4'd0;
              row_q      <= row_d;
              col_q      <= col_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status flags come straight from the state register; everything else is a
  // register already.
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.win_valid = (state_q == HOLD);
  assign bus.rd_en     = rdEn_q;
  assign bus.rd_addr   = rdAddr_q;
  assign bus.rgb_out0  = {pix_q[0], pix_q[1], pix_q[2]};
  assign bus.rgb_out1  = {pix_q[3], pix_q[4], pix_q[5]};
  assign bus.rgb_out2  = {pix_q[6], pix_q[7], pix_q[8]};
  assign bus.cur_row   = row_q;
  assign bus.cur_col   = col_q;

endmodule

// File: tb/tb_kernel_sched.sv
// -----------------------------------------------------------------------------
// tb_kernel_sched
// Directed bench for kernel_sched on a 4x3 image whose memory returns each
// pixel's own address as its value, one cycle after the read strobe.
// -----------------------------------------------------------------------------
module tb_kernel_sched;
  import kernel_sched_pkg::*;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  kernel_sched_if #(.ADDR_W(ADDR_W)) bus ();

  kernel_sched #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Pixel memory: each location holds its own address, returned one cycle
  // after the read strobe.
  always @(posedge clk) begin
    bus.rd_data <= bus.rd_en ? PIX_W'(bus.rd_addr) : '0;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive inputs at the falling edge so the next rising edge samples them.
  task automatic applyStimulus(input logic startV, input logic rstV,
                               input logic readyV);
    @(negedge clk);
    rst           = rstV;
    bus.start     = startV;
    bus.win_ready = readyV;
  endtask

  // Every output at its reset value.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"},      bus.busy,      0);
    checkOutput({tag, "_done"},      bus.done,      0);
    checkOutput({tag, "_rd_en"},     bus.rd_en,     0);
    checkOutput({tag, "_rd_addr"},   bus.rd_addr,   0);
    checkOutput({tag, "_win_valid"}, bus.win_valid, 0);
    checkOutput({tag, "_rgb0"},      bus.rgb_out0,  0);
    checkOutput({tag, "_rgb1"},      bus.rgb_out1,  0);
    checkOutput({tag, "_rgb2"},      bus.rgb_out2,  0);
    checkOutput({tag, "_cur_row"},   bus.cur_row,   0);
    checkOutput({tag, "_cur_col"},   bus.cur_col,   0);
  endtask

  // Bounded wait for a presented window; an expired bound counts as a failure.
  task automatic waitForValid(input string tag, input int maxCyc);
    int n = 0;
    while (bus.win_valid !== 1'b1 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, bus.win_valid, 1);
  endtask

  // Hand-computed windows and the first window's address sequence.
  localparam logic [35:0] W00_R0 = {12'd0, 12'd0, 12'd1};
  localparam logic [35:0] W00_R1 = {12'd0, 12'd0, 12'd1};
  localparam logic [35:0] W00_R2 = {12'd4, 12'd4, 12'd5};
  localparam logic [35:0] W01_R0 = {12'd0, 12'd1, 12'd2};
  localparam logic [35:0] W01_R1 = {12'd0, 12'd1, 12'd2};
  localparam logic [35:0] W01_R2 = {12'd4, 12'd5, 12'd6};
  localparam logic [35:0] W12_R0 = {12'd1, 12'd2, 12'd3};
  localparam logic [35:0] W12_R1 = {12'd5, 12'd6, 12'd7};
  localparam logic [35:0] W12_R2 = {12'd9, 12'd10, 12'd11};
  localparam logic [35:0] W23_R0 = {12'd6, 12'd7, 12'd7};
  localparam logic [35:0] W23_R1 = {12'd10, 12'd11, 12'd11};
  localparam logic [35:0] W23_R2 = {12'd10, 12'd11, 12'd11};

  logic [3:0] expAddr [9];
  logic [3:0] gotAddr [9];

  initial begin
    int windows;
    int spacingErr;
    int coordErr;
    int doneCnt;
    int doneCyc;
    int firstRdCyc;
    int firstReads;
    int zeroViol;

    expAddr = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd4, 4'd4, 4'd5};
    for (int i = 0; i < 9; i++) gotAddr[i] = '0;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.win_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("por");

    // Reset beats start in the same cycle.
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("rst_over_start_busy", bus.busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Full pass with win_ready held high; a stray start at cycle 50 must be
    // ignored.
    $display("[TB] full pass");
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    windows = 0; spacingErr = 0; coordErr = 0; doneCnt = 0; doneCyc = -1;
    firstRdCyc = -1; firstReads = 0; zeroViol = 0;
    for (int c = 1; c <= 140; c++) begin
      if (c == 50) bus.start = 1'b1;
      if (c == 51) bus.start = 1'b0;
      if (bus.rd_en === 1'b1) begin
        if (firstRdCyc < 0) firstRdCyc = c;
        if (c <= 10 && firstReads < 9) begin
          gotAddr[firstReads] = bus.rd_addr;
          firstReads++;
        end else if (c <= 10) begin
          firstReads++;
        end
      end else if (bus.rd_addr !== '0) begin
        zeroViol++;
      end
      if (bus.win_valid === 1'b1) begin
        if (c != 11 + 11 * windows) spacingErr++;
        if (int'(bus.cur_row) != windows / IMG_W ||
            int'(bus.cur_col) != windows % IMG_W) coordErr++;
        if (bus.cur_row == 0 && bus.cur_col == 0) begin
          checkOutput("w00_rgb0", bus.rgb_out0, W00_R0);
          checkOutput("w00_rgb1", bus.rgb_out1, W00_R1);
          checkOutput("w00_rgb2", bus.rgb_out2, W00_R2);
        end
        if (bus.cur_row == 1 && bus.cur_col == 2) begin
          checkOutput("w12_rgb0", bus.rgb_out0, W12_R0);
          checkOutput("w12_rgb1", bus.rgb_out1, W12_R1);
          checkOutput("w12_rgb2", bus.rgb_out2, W12_R2);
        end
        if (bus.cur_row == 2 && bus.cur_col == 3) begin
          checkOutput("w23_rgb0", bus.rgb_out0, W23_R0);
          checkOutput("w23_rgb1", bus.rgb_out1, W23_R1);
          checkOutput("w23_rgb2", bus.rgb_out2, W23_R2);
        end
        windows++;
      end
      if (bus.done === 1'b1) begin
        doneCnt++;
        doneCyc = c;
      end
      if (c == 134) checkOutput("busy_after_done", bus.busy, 0);
      @(negedge clk);
    end
    checkOutput("window_count", windows, 12);
    checkOutput("window_spacing_err", spacingErr, 0);
    checkOutput("window_coord_err", coordErr, 0);
    checkOutput("done_pulses", doneCnt, 1);
    checkOutput("done_cycle", doneCyc, 133);
    checkOutput("first_rd_cycle", firstRdCyc, 1);
    checkOutput("first_fetch_reads", firstReads, 9);
    checkOutput("idle_addr_nonzero", zeroViol, 0);
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("w00_addr%0d", i), gotAddr[i], expAddr[i]);
    end

    // Stall in HOLD for 20 cycles; a start pulse meanwhile must be ignored.
    $display("[TB] hold stall");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitForValid("stall_wait_valid", 30);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) bus.start = 1'b1;
      if (c == 6) bus.start = 1'b0;
      checkOutput("stall_valid",   bus.win_valid, 1);
      checkOutput("stall_rd_en",   bus.rd_en,     0);
      checkOutput("stall_cur_row", bus.cur_row,   0);
      checkOutput("stall_cur_col", bus.cur_col,   0);
      checkOutput("stall_rgb0",    bus.rgb_out0,  W00_R0);
      checkOutput("stall_rgb1",    bus.rgb_out1,  W00_R1);
      checkOutput("stall_rgb2",    bus.rgb_out2,  W00_R2);
      @(negedge clk);
    end

    // Accept once and look at the following window (0,1).
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("after_accept_valid", bus.win_valid, 0);
    waitForValid("w01_wait_valid", 30);
    checkOutput("w01_cur_row", bus.cur_row, 0);
    checkOutput("w01_cur_col", bus.cur_col, 1);
    checkOutput("w01_rgb0", bus.rgb_out0, W01_R0);
    checkOutput("w01_rgb1", bus.rgb_out1, W01_R1);
    checkOutput("w01_rgb2", bus.rgb_out2, W01_R2);

    // Reset beats win_ready while a window is held.
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkResetState("rst_in_hold");
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset in the fifth FETCH cycle of a fresh pass.
    $display("[TB] reset mid fetch");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("fetch_c4_rd_en", bus.rd_en, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkResetState("rst_mid_fetch");
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_sched.md
KERNEL_SCHED -- requirements
Module: kernel_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 640, image width in pixels (>=2).
REQ-002 SHALL have parameter IMG_H, default 480, image height in pixels (>=2).
REQ-003 SHALL have parameter ADDR_W, default 19, pixel-memory address width (>= clog2(IMG_W*IMG_H)).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  begin a full-image pass.
REQ-007 SHALL have port busy  output  1  pass in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse, pass complete.
REQ-009 SHALL have port rd_en  output  1  pixel-memory read strobe.
REQ-010 SHALL have port rd_addr  output  ADDR_W  pixel address = row*IMG_W + col.
REQ-011 SHALL have port rd_data  input  12  RGB444 pixel, valid exactly one cycle after rd_en.
REQ-012 SHALL have port win_valid  output  1  3x3 window presented.
REQ-013 SHALL have port win_ready  input  1  downstream (gray converter path) accepts window.
REQ-014 SHALL have ports rgb_out0/rgb_out1/rgb_out2  output  36 each  window rows r-1/r/r+1; bits [35:24]=col c-1, [23:12]=col c, [11:0]=col c+1; rgb_out1[23:12] is the centre pixel.
REQ-015 SHALL have ports cur_row/cur_col  output  16 each  centre coordinate of the current window.

Function
REQ-016 SHALL implement states IDLE, FETCH, HOLD, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-017 IDLE: start=1 at an edge SHALL clear cur_row=cur_col=0 and enter FETCH; start in any other state SHALL be ignored.
REQ-018 FETCH: SHALL issue 9 reads on 9 consecutive cycles, index k=0..8, row offset k/3-1, col offset k%3-1, rd_en=1 only on those cycles.
REQ-019 Each rd_data SHALL be captured the cycle after its read into the slot for k; FETCH lasts 10 cycles, then HOLD.
REQ-020 Out-of-range coordinates SHALL clamp (row -1->0, IMG_H->IMG_H-1, col -1->0, IMG_W->IMG_W-1) before address formation (edge replication).
REQ-021 rd_addr SHALL be computed at ADDR_W width without overflow; rd_addr SHALL be 0 when rd_en=0.
REQ-022 HOLD: win_valid=1; rgb_out*, cur_row, cur_col SHALL stay stable until win_valid&&win_ready at an edge.
REQ-023 On acceptance: if cur_col<IMG_W-1 then cur_col+1; else cur_col=0, cur_row+1; then FETCH.
REQ-024 On acceptance of window (IMG_H-1, IMG_W-1) SHALL enter DONE instead; DONE lasts one cycle, then IDLE.
REQ-025 win_ready while win_valid=0 SHALL have no effect; win_valid SHALL never deassert without acceptance except on rst.
REQ-026 Timing: start sampled at edge 0 -> rd_en cycles 1..9, win_valid from cycle 11 (ready held 1 gives 11 cycles per window).

Reset
REQ-027 rst=1 at an edge SHALL force IDLE from any state, including mid-FETCH and HOLD.
REQ-028 After reset SHALL hold busy=0, done=0, rd_en=0, rd_addr=0, win_valid=0, rgb_out0/1/2=0, cur_row=cur_col=0.
REQ-029 rst SHALL take priority over start and win_ready in the same cycle.

Structure
REQ-030 State enum (IDLE/FETCH/HOLD/DONE) and pixel width constant (12) SHALL reside in the shared coprocessor package.
REQ-031 Clamp-and-address logic SHALL be one sub-module, kernel_addr_gen (row, col, offsets -> clamped rd_addr); no other sub-modules.

Verification (IMG_W=4, IMG_H=3, memory pixel value = address)
REQ-032 start, win_ready=1 -> 12 windows, 11 cycles apart, then done pulse one cycle after 12th acceptance, busy low next cycle.
REQ-033 Window (0,0) -> rgb_out0={0,0,1}, rgb_out1={0,0,1}, rgb_out2={4,4,5} (corner clamp).
REQ-034 Window (1,2) -> rgb_out0={1,2,3}, rgb_out1={5,6,7}, rgb_out2={9,10,11}; window (2,3) -> rgb_out2={10,11,11}.
REQ-035 win_ready=0 for 20 cycles in HOLD -> win_valid stays 1, outputs and cur_row/cur_col unchanged, rd_en=0.
REQ-036 rst at cycle 5 of FETCH -> next cycle all outputs at reset values; start pulse during busy -> ignored, window count unchanged.
